// File: rtl/byte_pair_serializer.sv
// Serialises 16-bit words into two bytes presented on a downstream 8-bit 2:1 mux.
// Define BYTE_SWAP_EN to emit the high byte first; default build emits the low byte first.
module byte_pair_serializer (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [15:0] in_data,
   output logic [7:0]  mux_in0,
   output logic [7:0]  mux_in1,
   output logic        mux_sel,
   output logic        out_valid,
   input  logic        out_ready,
   output logic        busy,
   output logic [7:0]  byte_cnt
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SEND0 = 2'd1,
      SEND1 = 2'd2
   } state_t;

`ifdef BYTE_SWAP_EN
   localparam logic SEL_FIRST  = 1'b1;
   localparam logic SEL_SECOND = 1'b0;
`else
   localparam logic SEL_FIRST  = 1'b0;
   localparam logic SEL_SECOND = 1'b1;
`endif

   state_t state;
   state_t state_nxt;
   logic   accept;

   // in_ready is the only Mealy term: SEND1 can take a new word as its last byte leaves.
   always_comb begin
      in_ready = 1'b0;
      case (state)
         IDLE:    in_ready = 1'b1;
         SEND1:   in_ready = out_ready;
         default: in_ready = 1'b0;
      endcase
   end

   assign accept = in_valid & in_ready;

   always_comb begin
      state_nxt = state;
      out_valid = 1'b0;
      mux_sel   = 1'b0;
      busy      = 1'b1;
      case (state)
         IDLE: begin
            busy = 1'b0;
            if (accept) state_nxt = SEND0;
         end
         SEND0: begin
            out_valid = 1'b1;
            mux_sel   = SEL_FIRST;
            if (out_ready) state_nxt = SEND1;
         end
         SEND1: begin
            out_valid = 1'b1;
            mux_sel   = SEL_SECOND;
            if (out_ready) state_nxt = accept ? SEND0 : IDLE;
         end
         default: begin
            busy      = 1'b0;
            state_nxt = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mux_in0 <= '0;
         mux_in1 <= '0;
      end else if (accept) begin
         mux_in0 <= in_data[7:0];
         mux_in1 <= in_data[15:8];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         byte_cnt <= '0;
      end else if (out_valid && out_ready) begin
         byte_cnt <= byte_cnt + 8'd1;
      end
   end

endmodule

// File: tb/tb_byte_pair_serializer.sv
// Directed self-checking bench for byte_pair_serializer; honours BYTE_SWAP_EN for byte order.
module tb_byte_pair_serializer;

   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] in_data;
   logic [7:0]  mux_in0;
   logic [7:0]  mux_in1;
   logic        mux_sel;
   logic        out_valid;
   logic        out_ready;
   logic        busy;
   logic [7:0]  byte_cnt;
   logic [7:0]  mux_out;

   int unsigned errors = 0;
   int unsigned checks = 0;

`ifdef BYTE_SWAP_EN
   localparam bit SWAP = 1'b1;
`else
   localparam bit SWAP = 1'b0;
`endif

   byte_pair_serializer dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .mux_in0   (mux_in0),
      .mux_in1   (mux_in1),
      .mux_sel   (mux_sel),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .busy      (busy),
      .byte_cnt  (byte_cnt)
   );

   // Downstream 2:1 mux that the serializer feeds.
   assign mux_out = mux_sel ? mux_in1 : mux_in0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_byte(input string tag, input logic [15:0] word, input bit second);
      logic [7:0] exp_b;
      logic       exp_s;
      exp_s = second ^ SWAP;
      exp_b = exp_s ? word[15:8] : word[7:0];
      chk({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
      chk({tag, "_sel"}, {31'd0, mux_sel}, {31'd0, exp_s});
      chk({tag, "_byte"}, {24'd0, mux_out}, {24'd0, exp_b});
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_ready"}, {31'd0, in_ready}, 32'd1);
      chk({tag, "_valid"}, {31'd0, out_valid}, 32'd0);
      chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
      chk({tag, "_sel"}, {31'd0, mux_sel}, 32'd0);
      chk({tag, "_in0"}, {24'd0, mux_in0}, 32'd0);
      chk({tag, "_in1"}, {24'd0, mux_in1}, 32'd0);
      chk({tag, "_cnt"}, {24'd0, byte_cnt}, 32'd0);
   endtask

   initial begin
      logic [15:0] words [3];
      logic [15:0] w;
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      in_data   = 16'h0000;
      out_ready = 1'b0;
      #3;
      chk_reset_vals("por");

      // single word A55A, accepted on the first edge after release
      @(negedge clk);
      rst_n     = 1'b1;
      in_valid  = 1'b1;
      in_data   = 16'hA55A;
      out_ready = 1'b1;
      tick();
      in_valid = 1'b0;
      chk_byte("a55a_b0", 16'hA55A, 1'b0);
      chk("a55a_busy", {31'd0, busy}, 32'd1);
      tick();
      chk_byte("a55a_b1", 16'hA55A, 1'b1);
      tick();
      chk("a55a_idle_valid", {31'd0, out_valid}, 32'd0);
      chk("a55a_idle_busy", {31'd0, busy}, 32'd0);
      chk("a55a_cnt", {24'd0, byte_cnt}, 32'd2);

      // three words back to back, no bubble
      words[0] = 16'h0201;
      words[1] = 16'h0403;
      words[2] = 16'h0605;
      in_data  = words[0];
      in_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         if (i < 2) in_data = words[i+1];
         else       in_valid = 1'b0;
         chk_byte("b2b_lo", words[i], 1'b0);
         chk("b2b_ready_s0", {31'd0, in_ready}, 32'd0);
         tick();
         chk_byte("b2b_hi", words[i], 1'b1);
         chk("b2b_ready_s1", {31'd0, in_ready}, 32'd1);
      end
      tick();
      chk("b2b_idle", {31'd0, out_valid}, 32'd0);
      chk("b2b_cnt", {24'd0, byte_cnt}, 32'd8);

      // BEEF stalled in SEND0 while in_data churns
      in_data  = 16'hBEEF;
      in_valid = 1'b1;
      tick();
      out_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         in_data = 16'($urandom);
         #1;
         chk_byte("stall", 16'hBEEF, 1'b0);
         chk("stall_in0", {24'd0, mux_in0}, 32'h0000_00EF);
         chk("stall_in1", {24'd0, mux_in1}, 32'h0000_00BE);
         chk("stall_ready", {31'd0, in_ready}, 32'd0);
         tick();
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      #1;
      chk_byte("stall_rel_b0", 16'hBEEF, 1'b0);
      tick();
      chk_byte("stall_rel_b1", 16'hBEEF, 1'b1);
      tick();
      chk("stall_cnt", {24'd0, byte_cnt}, 32'd10);

      // reset pulse while in SEND1 drops the pending byte
      in_data  = 16'h1357;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      tick();
      chk_byte("rst_mid_s1", 16'h1357, 1'b1);
      chk("rst_mid_busy", {31'd0, busy}, 32'd1);
      rst_n = 1'b0;
      #1;
      chk_reset_vals("rst_mid");
      @(negedge clk);
      rst_n    = 1'b1;
      in_data  = 16'h2468;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      chk_byte("post_rst_b0", 16'h2468, 1'b0);
      tick();
      chk_byte("post_rst_b1", 16'h2468, 1'b1);
      tick();
      chk("post_rst_idle", {31'd0, out_valid}, 32'd0);
      chk("post_rst_cnt", {24'd0, byte_cnt}, 32'd2);

      // byte order check with word 1234
      in_data  = 16'h1234;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      chk("w1234_first", {24'd0, mux_out}, SWAP ? 32'h12 : 32'h34);
      tick();
      chk("w1234_second", {24'd0, mux_out}, SWAP ? 32'h34 : 32'h12);
      tick();
      chk("w1234_cnt", {24'd0, byte_cnt}, 32'd4);

      // clear the counter, then stream 130 words through the 255->0 wrap
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      chk("pre_stream_cnt", {24'd0, byte_cnt}, 32'd0);
      w        = 16'h0100;
      in_data  = w;
      in_valid = 1'b1;
      for (int i = 0; i < 130; i++) begin
         tick();
         if (i < 129) in_data = w + 16'h0202;
         else         in_valid = 1'b0;
         chk_byte("stream_lo", w, 1'b0);
         chk("stream_cnt_lo", {24'd0, byte_cnt}, 32'((2 * i) % 256));
         tick();
         chk_byte("stream_hi", w, 1'b1);
         chk("stream_cnt_hi", {24'd0, byte_cnt}, 32'((2 * i + 1) % 256));
         w = w + 16'h0202;
      end
      tick();
      chk("stream_idle", {31'd0, out_valid}, 32'd0);
      chk("stream_cnt_end", {24'd0, byte_cnt}, 32'd4);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
